// File: rtl/chessboard_pkg.sv
// Shared constants for the chessboard debug pattern: raster defaults, band tables, FSM states.
// Optional first-error capture in the checker is enabled by defining CHK_FIRST_ERR_EN.
package chessboard_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned COORD_W      = 11;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned CNT_W        = 19;

    localparam int unsigned NUM_X_EDGES = 25;
    localparam int unsigned NUM_Y_EDGES = 21;

    // Band i applies while coord < EDGES[i]; past the last edge the FINAL value applies.
    localparam logic [COORD_W-1:0] X_EDGES [NUM_X_EDGES] = '{
        11'd20,  11'd64,  11'd111, 11'd156, 11'd199, 11'd240, 11'd279, 11'd316, 11'd351,
        11'd384, 11'd415, 11'd444, 11'd471, 11'd496, 11'd519, 11'd540, 11'd559, 11'd576,
        11'd591, 11'd604, 11'd615, 11'd624, 11'd631, 11'd636, 11'd639
    };
    localparam logic [PIX_W-1:0] X_VALS [NUM_X_EDGES] = '{
        8'h00, 8'h01, 8'h04, 8'h09, 8'h19, 8'h24, 8'h31, 8'h79, 8'hA9, 8'hFF,
        8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF,
        8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00
    };
    localparam logic [PIX_W-1:0] X_FINAL = 8'hFF;

    localparam logic [COORD_W-1:0] Y_EDGES [NUM_Y_EDGES] = '{
        11'd39,  11'd80,  11'd119, 11'd156, 11'd191, 11'd224, 11'd255, 11'd284, 11'd311,
        11'd336, 11'd359, 11'd380, 11'd399, 11'd416, 11'd431, 11'd444, 11'd455, 11'd464,
        11'd471, 11'd476, 11'd479
    };
    localparam logic [PIX_W-1:0] Y_VALS [NUM_Y_EDGES] = '{
        8'h00, 8'h01, 8'h04, 8'h09, 8'h19, 8'h24, 8'h31, 8'h79, 8'hA9, 8'hE1,
        8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00,
        8'hFF
    };
    localparam logic [PIX_W-1:0] Y_FINAL = 8'h00;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StCheck,
        StReport
    } chk_state_e;

endpackage

// File: rtl/chessboard_band_lut.sv
// Combinational chessboard pattern: expected byte = vertical band(x) XOR horizontal band(y).
module chessboard_band_lut
    import chessboard_pkg::*;
(
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [PIX_W-1:0]   pix_o
);

    logic [PIX_W-1:0] vband;
    logic [PIX_W-1:0] hband;

    // Scanning from the highest edge down leaves the first matching edge's value.
    always_comb begin
        vband = X_FINAL;
        for (int i = int'(NUM_X_EDGES) - 1; i >= 0; i--) begin
            if (x_i < X_EDGES[i]) vband = X_VALS[i];
        end
        hband = Y_FINAL;
        for (int i = int'(NUM_Y_EDGES) - 1; i >= 0; i--) begin
            if (y_i < Y_EDGES[i]) hband = Y_VALS[i];
        end
        pix_o = vband ^ hband;
    end

endmodule

// File: rtl/chessboard_frame_checker.sv
// Checks returned chessboard pixels against the regenerated pattern and reports once per frame.
// Define CHK_FIRST_ERR_EN to capture the location of the first mismatch in each frame.
module chessboard_frame_checker
    import chessboard_pkg::*;
#(
    parameter int unsigned PIX_LATENCY = 1,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic [COORD_W-1:0] vga_x_i,
    input  logic [COORD_W-1:0] vga_y_i,
    input  logic               coord_valid_i,
    input  logic [PIX_W-1:0]   pix_data_i,
    output logic               frame_done_o,
    output logic               frame_pass_o,
    output logic               frame_trunc_o,
    output logic [CNT_W-1:0]   err_count_o,
    output logic [15:0]        frame_count_o,
    output logic [COORD_W-1:0] first_err_x_o,
    output logic [COORD_W-1:0] first_err_y_o,
    output logic               first_err_valid_o,
    output logic               busy_o
);

    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0]   PIX_TOTAL = CNT_W'(H_ACTIVE * V_ACTIVE);

    // Coordinate delay line aligning each coordinate with its returned pixel.
    logic [COORD_W-1:0] dly_x_q [PIX_LATENCY];
    logic [COORD_W-1:0] dly_y_q [PIX_LATENCY];
    logic               dly_v_q [PIX_LATENCY];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(PIX_LATENCY); i++) begin
                dly_x_q[i] <= '0;
                dly_y_q[i] <= '0;
                dly_v_q[i] <= 1'b0;
            end
        end else begin
            dly_x_q[0] <= vga_x_i;
            dly_y_q[0] <= vga_y_i;
            dly_v_q[0] <= coord_valid_i;
            for (int i = 1; i < int'(PIX_LATENCY); i++) begin
                dly_x_q[i] <= dly_x_q[i-1];
                dly_y_q[i] <= dly_y_q[i-1];
                dly_v_q[i] <= dly_v_q[i-1];
            end
        end
    end

    logic [COORD_W-1:0] cmp_x;
    logic [COORD_W-1:0] cmp_y;
    logic               cmp_v;
    logic [PIX_W-1:0]   exp_pix;
    logic               active;
    logic               at_origin;
    logic               at_last;
    logic               mismatch;

    assign cmp_x = dly_x_q[PIX_LATENCY-1];
    assign cmp_y = dly_y_q[PIX_LATENCY-1];
    assign cmp_v = dly_v_q[PIX_LATENCY-1];

    chessboard_band_lut u_lut (
        .x_i  (cmp_x),
        .y_i  (cmp_y),
        .pix_o(exp_pix)
    );

    assign active    = cmp_v && ({21'd0, cmp_x} < H_ACTIVE) && ({21'd0, cmp_y} < V_ACTIVE);
    assign at_origin = (cmp_x == '0) && (cmp_y == '0);
    assign at_last   = (cmp_x == X_LAST) && (cmp_y == Y_LAST);
    assign mismatch  = (pix_data_i != exp_pix);

    chk_state_e       state_q, state_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             trunc_q, trunc_d;
    logic             accumulate;
    logic             report;
    logic             clear_acc;

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        err_cnt_d  = err_cnt_q;
        trunc_d    = trunc_q;
        accumulate = 1'b0;
        report     = 1'b0;
        clear_acc  = 1'b0;
        if (!enable_i) begin
            state_d   = StIdle;
            clear_acc = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: state_d = StSync;
                StSync: begin
                    if (active && at_origin) begin
                        accumulate = 1'b1;
                        state_d    = StCheck;
                    end
                end
                StCheck: begin
                    if (active) begin
                        if (at_origin) begin
                            // Early restart: the new frame's origin pixel is dropped.
                            trunc_d = 1'b1;
                            state_d = StReport;
                        end else begin
                            accumulate = 1'b1;
                            if (at_last) state_d = StReport;
                        end
                    end
                end
                StReport: begin
                    report    = 1'b1;
                    clear_acc = 1'b1;
                    state_d   = StSync;
                end
                default: state_d = StIdle;
            endcase
        end
        if (clear_acc) begin
            pix_cnt_d = '0;
            err_cnt_d = '0;
            trunc_d   = 1'b0;
        end else if (accumulate) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            if (mismatch) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    logic             frame_done_q;
    logic             frame_pass_q;
    logic             frame_trunc_q;
    logic [CNT_W-1:0] err_count_q;
    logic [15:0]      frame_count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            pix_cnt_q     <= '0;
            err_cnt_q     <= '0;
            trunc_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_pass_q  <= 1'b0;
            frame_trunc_q <= 1'b0;
            err_count_q   <= '0;
            frame_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            err_cnt_q    <= err_cnt_d;
            trunc_q      <= trunc_d;
            frame_done_q <= report;
            if (report) begin
                frame_pass_q  <= (err_cnt_q == '0) && (pix_cnt_q == PIX_TOTAL) && !trunc_q;
                frame_trunc_q <= trunc_q;
                err_count_q   <= err_cnt_q;
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign frame_done_o  = frame_done_q;
    assign frame_pass_o  = frame_pass_q;
    assign frame_trunc_o = frame_trunc_q;
    assign err_count_o   = err_count_q;
    assign frame_count_o = frame_count_q;
    assign busy_o        = (state_q == StCheck);

`ifdef CHK_FIRST_ERR_EN
    logic [COORD_W-1:0] cap_x_q, cap_x_d;
    logic [COORD_W-1:0] cap_y_q, cap_y_d;
    logic               cap_seen_q, cap_seen_d;
    logic [COORD_W-1:0] fe_x_q;
    logic [COORD_W-1:0] fe_y_q;
    logic               fe_v_q;

    always_comb begin
        cap_x_d    = cap_x_q;
        cap_y_d    = cap_y_q;
        cap_seen_d = cap_seen_q;
        if (clear_acc) begin
            cap_x_d    = '0;
            cap_y_d    = '0;
            cap_seen_d = 1'b0;
        end else if (accumulate && mismatch && !cap_seen_q) begin
            cap_x_d    = cmp_x;
            cap_y_d    = cmp_y;
            cap_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cap_x_q    <= '0;
            cap_y_q    <= '0;
            cap_seen_q <= 1'b0;
            fe_x_q     <= '0;
            fe_y_q     <= '0;
            fe_v_q     <= 1'b0;
        end else begin
            cap_x_q    <= cap_x_d;
            cap_y_q    <= cap_y_d;
            cap_seen_q <= cap_seen_d;
            if (report) begin
                fe_x_q <= cap_x_q;
                fe_y_q <= cap_y_q;
                fe_v_q <= cap_seen_q;
            end
        end
    end

    assign first_err_x_o     = fe_x_q;
    assign first_err_y_o     = fe_y_q;
    assign first_err_valid_o = fe_v_q;
`else
    assign first_err_x_o     = '0;
    assign first_err_y_o     = '0;
    assign first_err_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_chessboard_frame_checker.sv
// Directed bench: reduced-size checkers at latency 1 and 3 plus a full-size checker for a band sweep.
module tb_chessboard_frame_checker;

    localparam int HA = 128;
    localparam int VA = 52;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        enable;
    logic [10:0] vga_x;
    logic [10:0] vga_y;
    logic        coord_valid;
    logic [7:0]  pix1;
    logic [7:0]  pix3;

    logic        done   [3];
    logic        pass   [3];
    logic        trunc  [3];
    logic [18:0] errc   [3];
    logic [15:0] fcnt   [3];
    logic [10:0] fex    [3];
    logic [10:0] fey    [3];
    logic        fev    [3];
    logic        busy   [3];

    chessboard_frame_checker #(.PIX_LATENCY(1), .H_ACTIVE(HA), .V_ACTIVE(VA)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .vga_x_i(vga_x), .vga_y_i(vga_y),
        .coord_valid_i(coord_valid), .pix_data_i(pix1), .frame_done_o(done[0]),
        .frame_pass_o(pass[0]), .frame_trunc_o(trunc[0]), .err_count_o(errc[0]),
        .frame_count_o(fcnt[0]), .first_err_x_o(fex[0]), .first_err_y_o(fey[0]),
        .first_err_valid_o(fev[0]), .busy_o(busy[0])
    );

    chessboard_frame_checker #(.PIX_LATENCY(3), .H_ACTIVE(HA), .V_ACTIVE(VA)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .vga_x_i(vga_x), .vga_y_i(vga_y),
        .coord_valid_i(coord_valid), .pix_data_i(pix3), .frame_done_o(done[1]),
        .frame_pass_o(pass[1]), .frame_trunc_o(trunc[1]), .err_count_o(errc[1]),
        .frame_count_o(fcnt[1]), .first_err_x_o(fex[1]), .first_err_y_o(fey[1]),
        .first_err_valid_o(fev[1]), .busy_o(busy[1])
    );

    chessboard_frame_checker #(.PIX_LATENCY(1), .H_ACTIVE(640), .V_ACTIVE(480)) u_full (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .vga_x_i(vga_x), .vga_y_i(vga_y),
        .coord_valid_i(coord_valid), .pix_data_i(pix1), .frame_done_o(done[2]),
        .frame_pass_o(pass[2]), .frame_trunc_o(trunc[2]), .err_count_o(errc[2]),
        .frame_count_o(fcnt[2]), .first_err_x_o(fex[2]), .first_err_y_o(fey[2]),
        .first_err_valid_o(fev[2]), .busy_o(busy[2])
    );

    // Reference pattern as band start points: band i covers [start_i, start_i+1).
    int x_start [26] = '{0, 20, 64, 111, 156, 199, 240, 279, 316, 351, 384, 415, 444, 471, 496,
                         519, 540, 559, 576, 591, 604, 615, 624, 631, 636, 639};
    logic [7:0] x_val [26] = '{8'h00, 8'h01, 8'h04, 8'h09, 8'h19, 8'h24, 8'h31, 8'h79, 8'hA9,
                               8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF,
                               8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    int y_start [22] = '{0, 39, 80, 119, 156, 191, 224, 255, 284, 311, 336, 359, 380, 399, 416,
                         431, 444, 455, 464, 471, 476, 479};
    logic [7:0] y_val [22] = '{8'h00, 8'h01, 8'h04, 8'h09, 8'h19, 8'h24, 8'h31, 8'h79, 8'hA9,
                               8'hE1, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00,
                               8'hFF, 8'h00, 8'hFF, 8'h00};

    function automatic logic [7:0] model(input int x, input int y);
        logic [7:0] vb;
        logic [7:0] hb;
        vb = x_val[0];
        hb = y_val[0];
        for (int i = 0; i < 26; i++) if (x >= x_start[i]) vb = x_val[i];
        for (int i = 0; i < 22; i++) if (y >= y_start[i]) hb = y_val[i];
        return vb ^ hb;
    endfunction

    // mode: 0 correct, 1 correct^1, 2 forced 0, 3 garbage
    typedef struct {
        int   x;
        int   y;
        logic v;
        int   mode;
    } ent_t;
    ent_t hist [4];

    function automatic logic [7:0] pix_for(input ent_t e);
        logic [7:0] xb;
        xb = 8'(e.x);
        if (!e.v) return 8'h00;
        case (e.mode)
            1:       return model(e.x, e.y) ^ 8'h01;
            2:       return 8'h00;
            3:       return 8'hA5 ^ xb;
            default: return model(e.x, e.y);
        endcase
    endfunction

    int cyc = 0;
    int end_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          dut;
        logic        pass;
        logic        trunc;
        logic [18:0] err;
        logic [15:0] cnt;
        logic [10:0] fx;
        logic [10:0] fy;
        logic        fv;
        int          at;
    } rep_t;
    rep_t repq[$];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done[d] === 1'b1)
                repq.push_back('{dut: d, pass: pass[d], trunc: trunc[d], err: errc[d],
                                 cnt: fcnt[d], fx: fex[d], fy: fey[d], fv: fev[d], at: cyc});
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic cmp(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input logic v, input int mode);
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = '{x: x, y: y, v: v, mode: mode};
        vga_x = 11'(x);
        vga_y = 11'(y);
        coord_valid = v;
        pix1 = pix_for(hist[1]);
        pix3 = pix_for(hist[3]);
        if (v && x == HA - 1 && y == VA - 1) end_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 0);
    endtask

    task automatic send_rows(input int y0, input int y1, input bit inject, input bit garbage);
        for (int y = y0; y < y1; y++) begin
            for (int x = 0; x < HA; x++) begin
                int m;
                m = 0;
                if (inject && x == 100 && y == 50) m = 1;
                if (inject && x == HA - 1 && y == VA - 1) m = 2;
                drive(x, y, 1'b1, m);
            end
            if (garbage) begin
                drive(700, y, 1'b1, 3);
                drive(HA + 3, y, 1'b1, 3);
                drive(5, 500, 1'b1, 3);
                drive(0, 0, 1'b0, 3);
            end
        end
    endtask

    task automatic check_report(input int d, input string tag, input int e_err, input bit e_pass,
                                input bit e_trunc, input int e_cnt, input bit e_fv,
                                input int e_fx, input int e_fy, input int e_lat);
        int   idx;
        rep_t r;
        idx = -1;
        for (int i = 0; i < repq.size(); i++) if (idx < 0 && repq[i].dut == d) idx = i;
        if (idx < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s dut%0d frame_done: got 0 reports, expected 1", tag, d);
        end else begin
            r = repq[idx];
            repq.delete(idx);
            cmp($sformatf("%s dut%0d err_count", tag, d), r.err, e_err);
            cmp($sformatf("%s dut%0d frame_pass", tag, d), r.pass, e_pass);
            cmp($sformatf("%s dut%0d frame_trunc", tag, d), r.trunc, e_trunc);
            cmp($sformatf("%s dut%0d frame_count", tag, d), r.cnt, e_cnt);
`ifdef CHK_FIRST_ERR_EN
            cmp($sformatf("%s dut%0d first_err_valid", tag, d), r.fv, e_fv);
            cmp($sformatf("%s dut%0d first_err_x", tag, d), r.fx, e_fx);
            cmp($sformatf("%s dut%0d first_err_y", tag, d), r.fy, e_fy);
`else
            cmp($sformatf("%s dut%0d first_err_valid", tag, d), r.fv, 0);
            cmp($sformatf("%s dut%0d first_err_x", tag, d), r.fx, 0);
            cmp($sformatf("%s dut%0d first_err_y", tag, d), r.fy, 0);
`endif
            if (e_lat >= 0)
                cmp($sformatf("%s dut%0d done latency", tag, d), r.at - end_cyc, e_lat + 2);
        end
    endtask

    task automatic check_none(input int d, input string tag);
        int n;
        n = 0;
        for (int i = 0; i < repq.size(); i++) if (repq[i].dut == d) n++;
        cmp($sformatf("%s dut%0d extra frame_done", tag, d), n, 0);
        for (int i = repq.size() - 1; i >= 0; i--) if (repq[i].dut == d) repq.delete(i);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            cmp($sformatf("%s dut%0d frame_done", tag, d), done[d], 0);
            cmp($sformatf("%s dut%0d frame_pass", tag, d), pass[d], 0);
            cmp($sformatf("%s dut%0d frame_trunc", tag, d), trunc[d], 0);
            cmp($sformatf("%s dut%0d err_count", tag, d), errc[d], 0);
            cmp($sformatf("%s dut%0d frame_count", tag, d), fcnt[d], 0);
            cmp($sformatf("%s dut%0d first_err", tag, d), {fev[d], fex[d], fey[d]}, 0);
            cmp($sformatf("%s dut%0d busy", tag, d), busy[d], 0);
        end
    endtask

    typedef struct {
        bit inject;
        bit garbage;
        int err;
        bit pass;
        int cnt;
        bit fv;
        int fx;
        int fy;
    } vec_t;
    vec_t vecs [3];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vecs[0] = '{0, 0, 0, 1, 1, 0, 0, 0};
        vecs[1] = '{1, 0, 2, 0, 2, 1, 100, 50};
        vecs[2] = '{0, 1, 0, 1, 3, 0, 0, 0};
        for (int i = 0; i < 4; i++) hist[i] = '{x: 0, y: 0, v: 1'b0, mode: 0};
        rst_n = 1'b0;
        enable = 1'b0;
        coord_valid = 1'b0;
        vga_x = '0;
        vga_y = '0;
        pix1 = '0;
        pix3 = '0;
        idle(3);
        rst_n = 1'b1;
        check_zero("reset");
        enable = 1'b1;
        idle(4);

        // Band sweep on the full-size checker: every edge and edge-1 in x and y.
        drive(0, 0, 1'b1, 0);
        k = 0;
        for (int yi = 0; yi < 43; yi++) begin
            for (int xi = 0; xi < 51; xi++) begin
                int xx;
                int yy;
                xx = (xi == 0) ? 0 : x_start[(xi + 1) / 2] - ((xi % 2 == 1) ? 1 : 0);
                yy = (yi == 0) ? 0 : y_start[(yi + 1) / 2] - ((yi % 2 == 1) ? 1 : 0);
                if (xx != 0 || yy != 0) begin
                    drive(xx, yy, 1'b1, 0);
                    k++;
                    if (k == 10) begin
                        @(negedge clk);
                        cmp("sweep dut2 busy", busy[2], 1);
                        cmp("sweep dut0 busy", busy[0], 1);
                    end
                end
            end
        end
        idle(6);
        check_report(2, "sweep", 0, 0, 0, 1, 0, 0, 0, -1);

        enable = 1'b0;
        idle(4);
        check_none(0, "disable");
        check_none(1, "disable");
        @(negedge clk);
        cmp("disable dut0 busy", busy[0], 0);
        enable = 1'b1;
        idle(4);

        for (int v = 0; v < 3; v++) begin
            send_rows(0, VA, vecs[v].inject, vecs[v].garbage);
            idle(8);
            for (int d = 0; d < 2; d++) begin
                check_report(d, $sformatf("vec%0d", v), vecs[v].err, vecs[v].pass, 0,
                             vecs[v].cnt, vecs[v].fv, vecs[v].fx, vecs[v].fy,
                             (d == 0) ? 1 : 3);
                check_none(d, $sformatf("vec%0d", v));
            end
        end

        // Early origin after 20 rows, then a frame whose remainder is ignored, then a clean one.
        send_rows(0, 20, 0, 0);
        send_rows(0, VA, 0, 0);
        idle(8);
        for (int d = 0; d < 2; d++) begin
            check_report(d, "trunc", 0, 0, 1, 4, 0, 0, 0, -1);
            check_none(d, "trunc");
        end
        send_rows(0, VA, 0, 0);
        idle(8);
        for (int d = 0; d < 2; d++) begin
            check_report(d, "after_trunc", 0, 1, 0, 5, 0, 0, 0, (d == 0) ? 1 : 3);
            check_none(d, "after_trunc");
        end

        send_rows(0, 10, 0, 0);
        enable = 1'b0;
        send_rows(10, 12, 0, 0);
        enable = 1'b1;
        send_rows(12, VA, 0, 0);
        idle(8);
        check_none(0, "enable_drop");
        check_none(1, "enable_drop");
        send_rows(0, VA, 0, 0);
        idle(8);
        for (int d = 0; d < 2; d++) begin
            check_report(d, "after_enable", 0, 1, 0, 6, 0, 0, 0, (d == 0) ? 1 : 3);
            check_none(d, "after_enable");
        end

        send_rows(0, 15, 0, 0);
        rst_n = 1'b0;
        drive(0, 15, 1'b1, 0);
        rst_n = 1'b1;
        check_zero("midreset");
        send_rows(15, VA, 0, 0);
        idle(8);
        check_none(0, "midreset");
        check_none(1, "midreset");
        send_rows(0, VA, 0, 0);
        idle(8);
        for (int d = 0; d < 2; d++) begin
            check_report(d, "after_reset", 0, 1, 0, 1, 0, 0, 0, (d == 0) ? 1 : 3);
            check_none(d, "after_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
